// File: rtl/spi_reg_responder_if.sv
// Bus bundle for spi_reg_responder: SPI pins, fabric sample input, write
// mirror and status.
//
// Handshake semantics: there is no ready anywhere on this bundle.
//   sample_valid  : single-cycle strobe; sample_x/y/z are qualified only in
//                   the cycle it is high and are always accepted.
//   reg_wr_valid  : single-cycle pulse; reg_wr_addr/reg_wr_data are
//                   qualified only in the cycle it is high and the consumer
//                   cannot stall it.
// state_dbg exposes the responder FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 DONE).
interface spi_reg_responder_if;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        sample_valid;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;
  logic        reg_wr_valid;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;
  logic [1:0]  state_dbg;

  // Host / fabric side.
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    output sample_valid, sample_x, sample_y, sample_z,
    input  spi_miso, reg_wr_valid, reg_wr_addr, reg_wr_data, busy, state_dbg
  );

  // Responder side.
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    input  sample_valid, sample_x, sample_y, sample_z,
    output spi_miso, reg_wr_valid, reg_wr_addr, reg_wr_data, busy, state_dbg
  );
endinterface

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-3 target emulating the ADXL345 register
// protocol over a 64 x 8 register file. All SPI pins are oversampled in
// sys_clk; there is no SCLK-clocked logic. Registers 0x32-0x37 are fed from
// the fabric sample input; host writes are mirrored as one-cycle pulses.
//
// Optional feature macro: SPI_REG_MULTIBYTE_EN
//   defined   : mb=1 frames continue past bit 16, one data byte per 8 bits,
//               address auto-increments and wraps 0x3F -> 0x00.
//   undefined : mb is ignored; after bit 16 the frame sits in DONE driving 0.
//
// SYNC_STAGES must be at least 2.
module spi_reg_responder #(
  parameter logic [7:0] DEVID_VALUE = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  spi_reg_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Synchronizer chains: index 0 is nearest the pin. A history flop after the
  // last stage gives the previous synced value for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_hist_q;
  logic                   cs_hist_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic busy;

  // FSM registers
  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_in_q;
  logic [7:0]  shift_in_d;
  logic [7:0]  rd_shift_q;
  logic        rw_q;
  logic [5:0]  addr_q;
  logic        miso_q;
  logic        wr_valid_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
`ifdef SPI_REG_MULTIBYTE_EN
  logic        mb_q;
  logic [5:0]  addr_next;
`endif

  // Register file and sample path
  logic [7:0]  regs_q [64];
  logic        host_wr_en;
  logic [7:0]  host_wr_data;
  logic        byte_end;
  logic        stage_valid_q;
  logic [47:0] stage_data_q;
  logic [47:0] shadow_q;
  logic        pending_q;
  logic        sample_now;
  logic        flush_now;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  // busy is the registered synced cs_n, inverted; it rises with the IDLE->ADDR step.
  assign busy      = ~cs_hist_q;

  assign shift_in_d   = {shift_in_q[6:0], mosi_s};
  assign byte_end     = sclk_rise && (bit_cnt_q == 3'd7);
  assign host_wr_data = shift_in_d;
  // CS edges take priority over SCLK edges in the FSM, so mirror that here.
  assign host_wr_en   = (state_q == ST_DATA) && byte_end && !rw_q &&
                        (addr_q != 6'h00) && !cs_rise && !cs_fall;
`ifdef SPI_REG_MULTIBYTE_EN
  assign addr_next    = addr_q + 6'd1;
`endif

  assign sample_now = bus.sample_valid && !busy;
  assign flush_now  = pending_q && !busy;

  // Synchronize SCLK, CS_n and MOSI into sys_clk; SCLK and CS_n idle high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b1;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
    end
  end

  // Frame FSM: samples MOSI on SCLK rise, drives MISO on SCLK fall.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_in_q <= 8'h00;
      rd_shift_q <= 8'h00;
      rw_q       <= 1'b0;
      addr_q     <= 6'h00;
      miso_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 6'h00;
      wr_data_q  <= 8'h00;
`ifdef SPI_REG_MULTIBYTE_EN
      mb_q       <= 1'b0;
`endif
    end else begin
      wr_valid_q <= 1'b0;
      if (cs_rise) begin
        // End of frame or abort: anything not yet committed is dropped.
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        miso_q    <= 1'b0;
      end else if (cs_fall) begin
        state_q    <= ST_ADDR;
        bit_cnt_q  <= 3'd0;
        shift_in_q <= 8'h00;
        miso_q     <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (sclk_rise) begin
          shift_in_q <= shift_in_d;
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (byte_end) begin
            case (state_q)
              ST_ADDR: begin
                rw_q       <= shift_in_d[7];
                addr_q     <= shift_in_d[5:0];
                rd_shift_q <= regs_q[shift_in_d[5:0]];
                state_q    <= ST_DATA;
`ifdef SPI_REG_MULTIBYTE_EN
                mb_q       <= shift_in_d[6];
`endif
              end
              ST_DATA: begin
                if (host_wr_en) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= host_wr_data;
                end
`ifdef SPI_REG_MULTIBYTE_EN
                if (mb_q) begin
                  addr_q     <= addr_next;
                  rd_shift_q <= regs_q[addr_next];
                end else begin
                  state_q <= ST_DONE;
                end
`else
                state_q <= ST_DONE;
`endif
              end
              default: ;
            endcase
          end
        end else if (sclk_fall) begin
          if ((state_q == ST_DATA) && rw_q) begin
            miso_q     <= rd_shift_q[7];
            rd_shift_q <= {rd_shift_q[6:0], 1'b0};
          end else begin
            miso_q <= 1'b0;
          end
        end
      end
    end
  end

  // Sample path: direct samples and deferred shadow copies share one staging register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= 48'h0;
      shadow_q      <= 48'h0;
      pending_q     <= 1'b0;
    end else begin
      stage_valid_q <= sample_now || flush_now;
      if (sample_now) begin
        stage_data_q <= {bus.sample_z, bus.sample_y, bus.sample_x};
      end else if (flush_now) begin
        stage_data_q <= shadow_q;
      end
      if (bus.sample_valid && busy) begin
        shadow_q  <= {bus.sample_z, bus.sample_y, bus.sample_x};
        pending_q <= 1'b1;
      end else if (!busy) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Register file: host write first, sample update second so the sample wins.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 64; i++) begin
        regs_q[i] <= (i == 0) ? DEVID_VALUE : 8'h00;
      end
    end else begin
      if (host_wr_en) begin
        regs_q[addr_q] <= host_wr_data;
      end
      if (stage_valid_q) begin
        regs_q[6'h32] <= stage_data_q[7:0];
        regs_q[6'h33] <= stage_data_q[15:8];
        regs_q[6'h34] <= stage_data_q[23:16];
        regs_q[6'h35] <= stage_data_q[31:24];
        regs_q[6'h36] <= stage_data_q[39:32];
        regs_q[6'h37] <= stage_data_q[47:40];
      end
    end
  end

  assign bus.spi_miso     = miso_q;
  assign bus.reg_wr_valid = wr_valid_q;
  assign bus.reg_wr_addr  = wr_addr_q;
  assign bus.reg_wr_data  = wr_data_q;
  assign bus.busy         = busy;
  assign bus.state_dbg    = state_q;

endmodule
